// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing SRAM port 0 between fetch (A) and load/store (B),
// with a fixed-latency response pipeline routing read data or write acks back.
module sram_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned MEMD       = 2048,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  a_req_i,
    output logic                  a_gnt_o,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH:0]   a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    input  logic [NUM_WMASKS-1:0] a_wmask_i,
    output logic                  a_rvalid_o,
    output logic [DATA_WIDTH-1:0] a_rdata_o,
    output logic                  a_err_o,
    input  logic                  b_req_i,
    output logic                  b_gnt_o,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH:0]   b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    input  logic [NUM_WMASKS-1:0] b_wmask_i,
    output logic                  b_rvalid_o,
    output logic [DATA_WIDTH-1:0] b_rdata_o,
    output logic                  b_err_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [NUM_WMASKS-1:0] sram_wmask_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_din_o,
    input  logic [DATA_WIDTH-1:0] sram_dout_i
);

    localparam int unsigned AW = ADDR_WIDTH + 1;

    typedef struct packed {
        logic valid;
        logic owner_b;
        logic we;
        logic err;
    } tag_t;

    logic                  last_gnt_b_q, last_gnt_b_d;
    logic                  any_gnt;
    logic                  sel_we;
    logic                  in_range;
    logic [AW-1:0]         sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [DATA_WIDTH-1:0] resp_data;
    tag_t                  stage0_d;
    tag_t                  resp;
    tag_t                  pipe_q [READ_LAT];

    // On contention the requester that did not win last time is favoured.
    always_comb begin
        a_gnt_o = rst_ni & a_req_i & (~b_req_i | last_gnt_b_q);
        b_gnt_o = rst_ni & b_req_i & (~a_req_i | ~last_gnt_b_q);
        any_gnt = a_gnt_o | b_gnt_o;
    end

    always_comb begin
        sel_we    = b_gnt_o ? b_we_i    : a_we_i;
        sel_addr  = b_gnt_o ? b_addr_i  : a_addr_i;
        sel_wdata = b_gnt_o ? b_wdata_i : a_wdata_i;
        sel_wmask = b_gnt_o ? b_wmask_i : a_wmask_i;
        in_range  = 32'(sel_addr) < 32'(MEMD);
    end

    // Out-of-range grants still occupy a pipeline slot but never touch the macro.
    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_addr_o  = '0;
        sram_din_o   = '0;
        sram_wmask_o = '0;
        if (any_gnt && in_range) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~sel_we;
            sram_addr_o  = sel_addr[ADDR_WIDTH-1:0];
            sram_din_o   = sel_wdata;
            sram_wmask_o = sel_wmask;
        end
    end

    always_comb begin
        last_gnt_b_d     = any_gnt ? b_gnt_o : last_gnt_b_q;
        stage0_d         = '0;
        stage0_d.valid   = any_gnt;
        stage0_d.owner_b = b_gnt_o;
        stage0_d.we      = sel_we;
        stage0_d.err     = any_gnt & ~in_range;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_b_q <= 1'b1;
        end else begin
            last_gnt_b_q <= last_gnt_b_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(READ_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage0_d;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // The last stage lines up with the cycle the macro presents read data.
    always_comb begin
        resp       = pipe_q[READ_LAT-1];
        resp_data  = (resp.valid && !resp.we && !resp.err) ? sram_dout_i : '0;
        a_rvalid_o = resp.valid & ~resp.owner_b;
        b_rvalid_o = resp.valid & resp.owner_b;
        a_err_o    = a_rvalid_o & resp.err;
        b_err_o    = b_rvalid_o & resp.err;
        a_rdata_o  = a_rvalid_o ? resp_data : '0;
        b_rdata_o  = b_rvalid_o ? resp_data : '0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a predictor models arbitration and memory
// contents at grant time, a monitor matches responses against the queue.
module tb_sram_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned AWD = 11;
    localparam int unsigned NM  = 4;
    localparam int unsigned MD  = 2048;
    localparam int unsigned RL  = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
    logic [AWD:0]    a_addr = '0, b_addr = '0;
    logic [DW-1:0]   a_wdata = '0, b_wdata = '0;
    logic [NM-1:0]   a_wmask = '0, b_wmask = '0;
    logic            a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err;
    logic [DW-1:0]   a_rdata, b_rdata;
    logic            sram_csb, sram_web;
    logic [NM-1:0]   sram_wmask;
    logic [AWD-1:0]  sram_addr;
    logic [DW-1:0]   sram_din, sram_dout;

    sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .NUM_WMASKS(NM), .MEMD(MD), .READ_LAT(RL)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_gnt_o(a_gnt), .a_we_i(a_we), .a_addr_i(a_addr),
        .a_wdata_i(a_wdata), .a_wmask_i(a_wmask), .a_rvalid_o(a_rvalid),
        .a_rdata_o(a_rdata), .a_err_o(a_err),
        .b_req_i(b_req), .b_gnt_o(b_gnt), .b_we_i(b_we), .b_addr_i(b_addr),
        .b_wdata_i(b_wdata), .b_wmask_i(b_wmask), .b_rvalid_o(b_rvalid),
        .b_rdata_o(b_rdata), .b_err_o(b_err),
        .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_wmask_o(sram_wmask),
        .sram_addr_o(sram_addr), .sram_din_o(sram_din), .sram_dout_i(sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro with READ_LAT-cycle read latency.
    logic [DW-1:0] mem [MD];
    logic [DW-1:0] dq  [RL];
    assign sram_dout = dq[RL-1];

    always @(posedge clk) begin
        if (!sram_csb && !sram_web) begin
            for (int k = 0; k < int'(NM); k++)
                if (sram_wmask[k]) mem[sram_addr][k*8 +: 8] <= sram_din[k*8 +: 8];
        end
        dq[0] <= (!sram_csb && sram_web) ? mem[sram_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < int'(RL); i++) dq[i] <= dq[i-1];
    end

    typedef struct {
        int          due;
        bit          owner_b;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t          q[$];
    logic [31:0]   ref_mem [MD];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            last_b = 1'b1;
    bit            a_was = 1'b0, b_was = 1'b0;
    logic [31:0]   last_a_data = '0, last_b_data = '0;
    bit            last_a_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // Predictor: reference arbitration and memory image, evaluated per cycle.
    always @(negedge clk) begin
        bit          ea, eb, we, inr;
        logic [11:0] ad;
        logic [31:0] wd, d;
        logic [3:0]  wm;
        exp_t        e;
        cyc++;
        if (!rst_n) begin
            chk("rst_a_gnt", 32'(a_gnt), 0);
            chk("rst_b_gnt", 32'(b_gnt), 0);
            chk("rst_csb", 32'(sram_csb), 1);
            chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 0);
            q.delete();
            last_b = 1'b1;
            a_was  = 1'b0;
            b_was  = 1'b0;
        end else begin
            ea = a_req && (!b_req || last_b);
            eb = b_req && (!a_req || !last_b);
            chk("a_gnt", 32'(a_gnt), 32'(ea));
            chk("b_gnt", 32'(b_gnt), 32'(eb));
            if (ea || eb) begin
                we  = eb ? b_we : a_we;
                ad  = eb ? b_addr : a_addr;
                wd  = eb ? b_wdata : a_wdata;
                wm  = eb ? b_wmask : a_wmask;
                inr = 32'(ad) < MD;
                chk("sram_csb", 32'(sram_csb), 32'(!inr));
                d = '0;
                if (inr) begin
                    chk("sram_web", 32'(sram_web), 32'(!we));
                    chk("sram_addr", 32'(sram_addr), 32'(ad));
                    if (we) begin
                        chk("sram_din", sram_din, wd);
                        chk("sram_wmask", 32'(sram_wmask), 32'(wm));
                        for (int k = 0; k < 4; k++)
                            if (wm[k]) ref_mem[ad][k*8 +: 8] = wd[k*8 +: 8];
                    end else begin
                        d = ref_mem[ad];
                    end
                end
                e.due = cyc + int'(RL); e.owner_b = eb; e.err = !inr; e.data = d;
                q.push_back(e);
                last_b = eb;
            end else begin
                chk("idle_csb", 32'(sram_csb), 1);
                chk("idle_web", 32'(sram_web), 1);
                chk("idle_addr", 32'(sram_addr), 0);
            end
            a_was = ea;
            b_was = eb;
        end
    end

    // Monitor: responses must arrive in grant order exactly at their due cycle.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.owner_b) begin
                    chk("b_rvalid", 32'(b_rvalid), 1);
                    chk("b_err", 32'(b_err), 32'(e.err));
                    chk("b_rdata", b_rdata, e.data);
                    chk("a_rvalid_nonowner", 32'({a_rvalid, a_err}), 0);
                    chk("a_rdata_nonowner", a_rdata, 0);
                    last_b_data = b_rdata;
                end else begin
                    chk("a_rvalid", 32'(a_rvalid), 1);
                    chk("a_err", 32'(a_err), 32'(e.err));
                    chk("a_rdata", a_rdata, e.data);
                    chk("b_rvalid_nonowner", 32'({b_rvalid, b_err}), 0);
                    chk("b_rdata_nonowner", b_rdata, 0);
                    last_a_data = a_rdata;
                    last_a_err  = a_err;
                end
            end else begin
                chk("no_rvalid", 32'({a_rvalid, b_rvalid}), 0);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_a(input bit rq, input bit w, input int ad, input logic [31:0] wd, input logic [3:0] wm);
        a_req = rq; a_we = w; a_addr = 12'(ad); a_wdata = wd; a_wmask = wm;
    endtask

    task automatic drive_b(input bit rq, input bit w, input int ad, input logic [31:0] wd, input logic [3:0] wm);
        b_req = rq; b_we = w; b_addr = 12'(ad); b_wdata = wd; b_wmask = wm;
    endtask

    function automatic int rand_addr();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(2048, 4095)) : int'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < int'(MD); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < int'(RL); i++) dq[i] = '0;

        // Reset with both requesting, then A wins the first contention.
        drive_a(1, 0, 0, 0, 0);
        drive_b(1, 0, 1, 0, 0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        tick(3);

        // B write then read-after-write.
        drive_b(1, 1, 5, 32'hDEADBEEF, 4'hF);
        tick(1);
        drive_b(1, 0, 5, 0, 0);
        tick(1);
        drive_b(0, 0, 0, 0, 0);
        tick(RL + 2);
        chk("raw_deadbeef", last_b_data, 32'hDEADBEEF);

        // Sustained contention.
        drive_a(1, 0, 5, 0, 0);
        drive_b(1, 0, 7, 0, 0);
        tick(6);
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        tick(RL + 2);

        // Partial byte-lane write.
        drive_a(1, 1, 100, 32'h11223344, 4'hF);
        tick(1);
        drive_a(1, 1, 100, 32'hAABBCCDD, 4'h2);
        tick(1);
        drive_a(1, 0, 100, 0, 0);
        tick(1);
        drive_a(0, 0, 0, 0, 0);
        tick(RL + 2);
        chk("byte_mask", last_a_data, 32'h1122CC44);

        // Out-of-range read.
        drive_a(1, 0, 2048, 0, 0);
        tick(1);
        drive_a(0, 0, 0, 0, 0);
        tick(RL + 2);
        chk("err_flag", 32'(last_a_err), 1);
        chk("err_rdata", last_a_data, 0);

        // Reset while a read is in flight; its response must vanish.
        drive_a(1, 0, 5, 0, 0);
        tick(1);
        rst_n = 1'b0;
        drive_a(0, 0, 0, 0, 0);
        tick(2);
        rst_n = 1'b1;
        tick(RL + 4);

        // Randomised traffic; requests are held until granted.
        for (int c = 0; c < 3000; c++) begin
            if (!a_req || a_was) begin
                drive_a($urandom_range(0, 9) < 7, $urandom_range(0, 1), rand_addr(), $urandom, 4'($urandom));
            end else if ($urandom_range(0, 4) == 0) begin
                a_addr = 12'(rand_addr());
                a_wdata = $urandom;
            end
            if (!b_req || b_was) begin
                drive_b($urandom_range(0, 9) < 7, $urandom_range(0, 1), rand_addr(), $urandom, 4'($urandom));
            end else if ($urandom_range(0, 4) == 0) begin
                b_addr = 12'(rand_addr());
                b_wdata = $urandom;
            end
            tick(1);
        end
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        tick(RL + 3);
        chk("queue_drained", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
